// File: rtl/dfa_flow_ctx_ctrl.sv
// Per-flow DFA context scheduler: restores a flow's saved state into the match
// engine at packet start, streams bytes, reports accepts, saves state at packet end.
module dfa_flow_ctx_ctrl #(
    parameter int unsigned NUM_FLOWS = 16,
    parameter int unsigned FLOW_W    = 4,
    parameter int unsigned STATE_W   = 11,
    parameter int unsigned OFS_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [FLOW_W-1:0]  in_flow,
    input  logic               clr_valid,
    input  logic [FLOW_W-1:0]  clr_flow,
    output logic [7:0]         eng_char,
    output logic               eng_char_vld,
    output logic [STATE_W-1:0] eng_state_in,
    output logic               eng_state_in_vld,
    input  logic [STATE_W-1:0] eng_state_out,
    input  logic               eng_accept,
    output logic               match_valid,
    output logic [FLOW_W-1:0]  match_flow,
    output logic [OFS_W-1:0]   match_offset,
    output logic               busy,
    output logic               err_sop,
    output logic [15:0]        drop_cnt
);

    localparam int unsigned DROP_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_SAVE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FLOW_W-1:0]   cur_flow_q, cur_flow_d;
    logic [OFS_W-1:0]    offset_q, offset_d;
    logic                first_q, first_d;
    logic                clr_pend_q, clr_pend_d;
    logic                err_sop_q, err_sop_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                match_valid_q, match_valid_d;
    logic [FLOW_W-1:0]   match_flow_q, match_flow_d;
    logic [OFS_W-1:0]    match_offset_q, match_offset_d;
    logic [STATE_W-1:0]  ctx_q [NUM_FLOWS];
    logic [STATE_W-1:0]  ctx_d [NUM_FLOWS];

    logic                hs;

    // Engine drive and input handshake; held at zero while reset is asserted
    always_comb begin
        in_ready         = 1'b0;
        eng_char         = 8'd0;
        eng_char_vld     = 1'b0;
        eng_state_in     = '0;
        eng_state_in_vld = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: in_ready = !in_sop;
                S_LOAD: begin
                    eng_state_in     = ctx_q[cur_flow_q];
                    eng_state_in_vld = 1'b1;
                end
                S_RUN: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        eng_char     = in_data;
                        eng_char_vld = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        hs = in_valid & in_ready;
    end

    // Next-state, context table update and match capture
    always_comb begin
        state_d        = state_q;
        cur_flow_d     = cur_flow_q;
        offset_d       = offset_q;
        first_d        = first_q;
        clr_pend_d     = clr_pend_q;
        err_sop_d      = err_sop_q;
        drop_cnt_d     = drop_cnt_q;
        match_valid_d  = eng_accept & eng_char_vld;
        match_flow_d   = match_flow_q;
        match_offset_d = match_offset_q;
        ctx_d          = ctx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    cur_flow_d = in_flow;
                    state_d    = S_LOAD;
                end else if (hs && drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
            S_LOAD: begin
                offset_d = '0;
                first_d  = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (hs) begin
                    if (offset_q != '1) begin
                        offset_d = offset_q + OFS_W'(1);
                    end
                    first_d = 1'b0;
                    // The held sop beat of the current packet is its first byte
                    if (in_sop && !first_q) begin
                        err_sop_d = 1'b1;
                    end
                    if (in_eop) begin
                        state_d = S_SAVE;
                    end
                end
            end
            S_SAVE: begin
                ctx_d[cur_flow_q] = clr_pend_q ? '0 : eng_state_out;
                clr_pend_d        = 1'b0;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (eng_accept && eng_char_vld) begin
            match_flow_d   = cur_flow_q;
            match_offset_d = offset_q;
        end

        // Clear applied last so it wins over a same-cycle save
        if (clr_valid) begin
            ctx_d[clr_flow] = '0;
            if ((state_q == S_LOAD || state_q == S_RUN) && clr_flow == cur_flow_q) begin
                clr_pend_d = 1'b1;
            end
        end
    end

    // State and context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cur_flow_q     <= '0;
            offset_q       <= '0;
            first_q        <= 1'b0;
            clr_pend_q     <= 1'b0;
            err_sop_q      <= 1'b0;
            drop_cnt_q     <= '0;
            match_valid_q  <= 1'b0;
            match_flow_q   <= '0;
            match_offset_q <= '0;
            for (int i = 0; i < int'(NUM_FLOWS); i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cur_flow_q     <= cur_flow_d;
            offset_q       <= offset_d;
            first_q        <= first_d;
            clr_pend_q     <= clr_pend_d;
            err_sop_q      <= err_sop_d;
            drop_cnt_q     <= drop_cnt_d;
            match_valid_q  <= match_valid_d;
            match_flow_q   <= match_flow_d;
            match_offset_q <= match_offset_d;
            ctx_q          <= ctx_d;
        end
    end

    assign match_valid  = match_valid_q;
    assign match_flow   = match_flow_q;
    assign match_offset = match_offset_q;
    assign busy         = (state_q != S_IDLE);
    assign err_sop      = err_sop_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_dfa_flow_ctx_ctrl.sv
// Bench for dfa_flow_ctx_ctrl with a counting engine stub and a packet-level model.
module tb_dfa_flow_ctx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic [3:0]  in_flow;
    logic        clr_valid;
    logic [3:0]  clr_flow;
    logic [7:0]  eng_char;
    logic        eng_char_vld;
    logic [10:0] eng_state_in;
    logic        eng_state_in_vld;
    logic [10:0] eng_state_out;
    logic        eng_accept;
    logic        match_valid;
    logic [3:0]  match_flow;
    logic [15:0] match_offset;
    logic        busy;
    logic        err_sop;
    logic [15:0] drop_cnt;

    dfa_flow_ctx_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_flow(in_flow),
        .clr_valid(clr_valid), .clr_flow(clr_flow),
        .eng_char(eng_char), .eng_char_vld(eng_char_vld),
        .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
        .eng_state_out(eng_state_out), .eng_accept(eng_accept),
        .match_valid(match_valid), .match_flow(match_flow), .match_offset(match_offset),
        .busy(busy), .err_sop(err_sop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Engine stub: state+1 per char, accept when the next state is 5
    logic [10:0] eng_st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   eng_st <= 11'd0;
        else if (eng_state_in_vld) eng_st <= eng_state_in;
        else if (eng_char_vld)     eng_st <= 11'(eng_st + 11'd1);
    end
    assign eng_state_out = eng_st;
    assign eng_accept    = eng_char_vld && (11'(eng_st + 11'd1) == 11'd5);

    typedef struct { int flow; int off; } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   mctx [16];
    exp_t expq [$];
    int   exp_load  = 0;
    int   last_load = -1;
    int   last_mflow = -1;
    int   last_moff  = -1;
    int   nmatch = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the packet-level model
    always @(negedge clk) begin
        if (!rst) begin
            chk("dual_vld", int'(eng_state_in_vld && eng_char_vld), 0);
            if (eng_char_vld) chk("char_vld_when_idle", int'(busy), 1);
            if (eng_state_in_vld) begin
                chk("load_state", int'(eng_state_in), exp_load);
                last_load = int'(eng_state_in);
            end
            if (match_valid) begin
                nmatch++;
                last_mflow = int'(match_flow);
                last_moff  = int'(match_offset);
                if (expq.size() == 0) begin
                    chk("unexpected_match", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("match_flow", int'(match_flow), e.flow);
                    chk("match_offset", int'(match_offset), e.off);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Send an n-byte packet; sop_pos marks an extra mid-packet sop (-1: none)
    task automatic send_pkt(input int flow, input int n, input int sop_pos);
        int base = mctx[flow];
        exp_load = base;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            if (((base + i + 1) % 2048) == 5) begin
                e.flow = flow; e.off = i;
                expq.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            in_sop   = (i == 0) || (i == sop_pos);
            in_eop   = (i == n - 1);
            in_flow  = 4'(flow);
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1; break; end
            end
            if (!ok) chk("hs_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        mctx[flow] = (base + n) % 2048;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy [4];
        foreach (mctx[i]) mctx[i] = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_sop = 1'b0; in_eop = 1'b0;
        in_flow = 4'd0; clr_valid = 1'b0; clr_flow = 4'd0;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_err_sop", int'(err_sop), 0);
        chk("rst_match", int'(match_valid), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Flow 3: 3-byte then 4-byte packet
        send_pkt(3, 3, -1);
        chk("f3_p1_load", last_load, 0);
        chk("f3_p1_nomatch", nmatch, 0);
        send_pkt(3, 4, -1);
        chk("f3_p2_load", last_load, 3);
        chk("f3_p2_mflow", last_mflow, 3);
        chk("f3_p2_moff", last_moff, 1);

        // Interleaved flows 1 and 2
        send_pkt(1, 2, -1);
        send_pkt(2, 2, -1);
        send_pkt(1, 3, -1);
        chk("f1_load", last_load, 2);
        chk("f1_mflow", last_mflow, 1);
        chk("f1_moff", last_moff, 2);
        send_pkt(2, 1, -1);
        chk("f2_ctx", last_load, 2);

        // Non-sop beats in IDLE are dropped
        in_valid = 1'b1; in_sop = 1'b0;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("drop5", int'(drop_cnt), 5);

        // Clear flow 4 during its RUN
        send_pkt(4, 2, -1);
        fork
            send_pkt(4, 4, -1);
            begin
                repeat (4) @(posedge clk);
                #1 clr_valid = 1'b1; clr_flow = 4'd4;
                @(posedge clk);
                #1 clr_valid = 1'b0;
            end
        join
        mctx[4] = 0;
        send_pkt(4, 1, -1);
        chk("f4_cleared", last_load, 0);

        // Clear flow 6 in the same cycle as its SAVE
        send_pkt(6, 1, -1);
        fork
            send_pkt(6, 2, -1);
            begin
                repeat (4) @(posedge clk);
                #1 clr_valid = 1'b1; clr_flow = 4'd6;
                @(posedge clk);
                #1 clr_valid = 1'b0;
            end
        join
        mctx[6] = 0;
        send_pkt(6, 1, -1);
        chk("f6_cleared", last_load, 0);

        // Mid-packet sop
        chk("err_sop_pre", int'(err_sop), 0);
        send_pkt(7, 5, 2);
        chk("err_sop_set", int'(err_sop), 1);
        send_pkt(7, 1, -1);
        chk("f7_ctx", last_load, 5);
        chk("err_sop_held", int'(err_sop), 1);

        // Single sop+eop byte with in_valid held high
        exp_load = mctx[9];
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_flow = 4'd9; in_data = 8'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy[k] = int'(in_ready);
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        mctx[9] = mctx[9] + 1;
        chk("rdy_idle", rdy[0], 0);
        chk("rdy_load", rdy[1], 0);
        chk("rdy_run",  rdy[2], 1);
        chk("rdy_save", rdy[3], 0);
        wait_idle();
        send_pkt(9, 1, -1);
        chk("f9_ctx", last_load, 1);

        // Reset mid-RUN aborts the packet
        exp_load = mctx[3];
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_flow = 4'd3; in_data = 8'h22;
        repeat (3) @(posedge clk);
        #1 in_sop = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_char_vld", int'(eng_char_vld), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_err_sop", int'(err_sop), 0);
        in_valid = 1'b0;
        foreach (mctx[i]) mctx[i] = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send_pkt(3, 1, -1);
        chk("post_rst_f3", last_load, 0);
        send_pkt(1, 1, -1);
        chk("post_rst_f1", last_load, 0);

        // Drop counter saturation
        in_valid = 1'b1; in_sop = 1'b0;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("drop_sat", int'(drop_cnt), 65535);

        chk("match_count", nmatch, 4);
        chk("expq_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
